// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider.
//   state_t         : controller states (IDLE, CALC, DONE)
//   RANGE_WIDTH_DEF : default dividend/quotient width
//   HALF_WIDTH_DEF  : default divisor/remainder width
//   CNT_WIDTH_DEF   : default step-counter width
//   half_width()/cnt_width() derive the same constants for any RANGE_WIDTH.
package div_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam int RANGE_WIDTH_DEF = 16;
  localparam int HALF_WIDTH_DEF  = RANGE_WIDTH_DEF / 2;
  localparam int CNT_WIDTH_DEF   = $clog2(RANGE_WIDTH_DEF);

  function automatic int half_width(input int w);
    return w / 2;
  endfunction

  // Counter only has to reach w-1, the index of the last step.
  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step.
// Ports:
//   prem_in  : partial remainder before this step (HALF_W+1 bits)
//   bit_in   : next dividend bit, MSB first
//   divisor  : divisor (HALF_W bits)
//   prem_out : partial remainder after the step
//   q_bit    : quotient bit produced by the step
module div_step
  import div_pkg::*;
#(
  parameter int HALF_W = HALF_WIDTH_DEF
) (
  input  logic [HALF_W:0]   prem_in,
  input  logic              bit_in,
  input  logic [HALF_W-1:0] divisor,
  output logic [HALF_W:0]   prem_out,
  output logic              q_bit
);

  logic [HALF_W:0] shifted;
  logic [HALF_W:0] diff;
  logic            unused_prem_top;

  // A restored remainder is always below the divisor, so its top bit is
  // zero and can be shifted out without loss.
  assign unused_prem_top = prem_in[HALF_W];
  assign shifted         = {prem_in[HALF_W-1:0], bit_in};
  assign diff            = shifted - {1'b0, divisor};
  assign q_bit           = (shifted >= {1'b0, divisor});
  assign prem_out        = q_bit ? diff : shifted;

endmodule

// File: rtl/seq_divide.sv
// Sequential restoring divider: one quotient bit per clock, MSB first.
// Optional feature macro: SEQ_DIVIDE_ZERO_CHECK_EN -- a zero divisor skips
// the iteration and reports div_zero in the cycle after start.
// Ports:
//   clk       : rising-edge clock
//   reset     : synchronous, active-low reset
//   start     : request, sampled only while ready=1
//   dividend  : numerator (RANGE_WIDTH bits), captured on accepted start
//   divisor   : denominator (RANGE_WIDTH/2 bits), captured on accepted start
//   ready     : high only in IDLE
//   out_valid : one-cycle pulse marking a new result
//   quotient  : floor(dividend/divisor), held until next result
//   remainder : dividend mod divisor, held until next result
//   div_zero  : divisor was zero (always 0 without the macro)
module seq_divide
  import div_pkg::*;
#(
  parameter int RANGE_WIDTH = RANGE_WIDTH_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [RANGE_WIDTH-1:0]     dividend,
  input  logic [RANGE_WIDTH/2-1:0]   divisor,
  output logic                       ready,
  output logic                       out_valid,
  output logic [RANGE_WIDTH-1:0]     quotient,
  output logic [RANGE_WIDTH/2-1:0]   remainder,
  output logic                       div_zero
);

  localparam int HALF_W = half_width(RANGE_WIDTH);
  localparam int CNT_W  = cnt_width(RANGE_WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(RANGE_WIDTH - 1);

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    step_cnt;
  logic                accept;
  logic                zero_start;
  logic                last_step;

  // dq_sh shifts dividend bits out of the top and quotient bits in at the
  // bottom, so after RANGE_WIDTH steps it holds the full quotient.
  logic [RANGE_WIDTH-1:0] dq_sh;
  logic [HALF_W:0]        prem;
  logic [HALF_W-1:0]      dvs;
  logic [HALF_W:0]        prem_nxt;
  logic                   q_bit;

  assign accept    = start && (state == IDLE);
  assign last_step = (state == CALC) && (step_cnt == LAST_STEP);

`ifdef SEQ_DIVIDE_ZERO_CHECK_EN
  assign zero_start = accept && (divisor == '0);
`else
  assign zero_start = 1'b0;
`endif

  div_step #(.HALF_W(HALF_W)) u_step (
    .prem_in  (prem),
    .bit_in   (dq_sh[RANGE_WIDTH-1]),
    .divisor  (dvs),
    .prem_out (prem_nxt),
    .q_bit    (q_bit)
  );

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) state_nxt = zero_start ? DONE : CALC;
      end
      CALC: begin
        if (step_cnt == LAST_STEP) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture and iteration; these never need a reset because they
  // are always reloaded before CALC is entered.
  always_ff @(posedge clk) begin
    if (accept) begin
      dq_sh <= dividend;
      prem  <= '0;
      dvs   <= divisor;
    end else if (state == CALC) begin
      dq_sh <= {dq_sh[RANGE_WIDTH-2:0], q_bit};
      prem  <= prem_nxt;
    end
  end

  // Step counter and result registers, written only on entry to DONE.
  always_ff @(posedge clk) begin
    if (!reset) begin
      step_cnt  <= '0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      if (state == CALC) step_cnt <= last_step ? '0 : step_cnt + CNT_W'(1);
      else               step_cnt <= '0;
      if (last_step) begin
        quotient  <= {dq_sh[RANGE_WIDTH-2:0], q_bit};
        remainder <= prem_nxt[HALF_W-1:0];
      end else if (zero_start) begin
        quotient  <= '1;
        remainder <= dividend[HALF_W-1:0];
      end
    end
  end

`ifdef SEQ_DIVIDE_ZERO_CHECK_EN
  logic div_zero_q;
  always_ff @(posedge clk) begin
    if (!reset)          div_zero_q <= 1'b0;
    else if (last_step)  div_zero_q <= 1'b0;
    else if (zero_start) div_zero_q <= 1'b1;
  end
  assign div_zero = div_zero_q;
`else
  assign div_zero = 1'b0;
`endif

endmodule

// File: tb/tb_seq_divide.sv
module tb_seq_divide;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        ready;
  logic        out_valid;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div_zero;

  seq_divide #(.RANGE_WIDTH(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .ready     (ready),
    .out_valid (out_valid),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] q;
    logic [7:0]  r;
    logic        z;
    bit          chk_r;
    int          t0;
    int          lat;
    string       name;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per out_valid pulse.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (out_valid === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out_valid: got valid at cycle %0d expected none", cyc);
        end else begin
          e = sb.pop_front();
          chk({e.name, "_quotient"}, 32'(quotient), 32'(e.q));
          if (e.chk_r) chk({e.name, "_remainder"}, 32'(remainder), 32'(e.r));
          chk({e.name, "_div_zero"}, 32'(div_zero), 32'(e.z));
          chk({e.name, "_latency"}, 32'(cyc - e.t0), 32'(e.lat));
        end
      end
    end
  end

  task automatic wait_ready(output bit ok);
    int n;
    n = 0;
    @(negedge clk);
    while (ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    ok = (n < 100);
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got ready=%0d expected 1 within 100 cycles", ready);
    end
  endtask

  task automatic run_div(input logic [15:0] dvd, input logic [7:0] dvs,
                         input logic [15:0] q, input logic [7:0] r, input logic z,
                         input bit chk_r, input int lat, input string name);
    bit   ok;
    exp_t e;
    wait_ready(ok);
    if (!ok) return;
    dividend = dvd;
    divisor  = dvs;
    start    = 1'b1;
    e.q = q; e.r = r; e.z = z; e.chk_r = chk_r; e.t0 = cyc; e.lat = lat; e.name = name;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    bit          ok;
    exp_t        e;
    logic [15:0] p;
    logic [7:0]  a, b;

    reset = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_quotient", 32'(quotient), 32'd0);
    chk("rst_remainder", 32'(remainder), 32'd0);
    chk("rst_div_zero", 32'(div_zero), 32'd0);
    reset = 1'b1;

    run_div(16'd65025, 8'd255, 16'd255, 8'd0, 1'b0, 1'b1, 17, "sq255");
    run_div(16'd1000, 8'd7, 16'd142, 8'd6, 1'b0, 1'b1, 17, "d1000_7");
    run_div(16'd5, 8'd200, 16'd0, 8'd5, 1'b0, 1'b1, 17, "small_dvd");
    run_div(16'd65535, 8'd255, 16'd257, 8'd0, 1'b0, 1'b1, 17, "max_max");
    run_div(16'd254, 8'd255, 16'd0, 8'd254, 1'b0, 1'b1, 17, "just_below");
    run_div(16'd0, 8'd5, 16'd0, 8'd0, 1'b0, 1'b1, 17, "zero_dvd");

    // Busy-time starts with different operands must be ignored.
    wait_ready(ok);
    if (ok) begin
      dividend = 16'd65535; divisor = 8'd1; start = 1'b1;
      e.q = 16'd65535; e.r = 8'd0; e.z = 1'b0; e.chk_r = 1'b1;
      e.t0 = cyc; e.lat = 17; e.name = "ign_start";
      sb.push_back(e);
      @(negedge clk); start = 1'b0;
      repeat (2) @(negedge clk);
      dividend = 16'd7; divisor = 8'd3; start = 1'b1;
      chk("busy_ready_c3", 32'(ready), 32'd0);
      @(negedge clk); start = 1'b0;
      repeat (6) @(negedge clk);
      start = 1'b1;
      chk("busy_ready_c10", 32'(ready), 32'd0);
      @(negedge clk); start = 1'b0;
    end

`ifdef SEQ_DIVIDE_ZERO_CHECK_EN
    run_div(16'd1234, 8'd0, 16'd65535, 8'd210, 1'b1, 1'b1, 1, "div0");
`else
    run_div(16'd1234, 8'd0, 16'd65535, 8'd0, 1'b0, 1'b0, 17, "div0");
`endif
    run_div(16'd300, 8'd17, 16'd17, 8'd11, 1'b0, 1'b1, 17, "after_div0");

    // Abort at CALC step 8 with reset; no result may appear.
    wait_ready(ok);
    if (ok) begin
      dividend = 16'd500; divisor = 8'd3; start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (7) @(negedge clk);
      reset = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("abort_ready", 32'(ready), 32'd1);
      chk("abort_out_valid", 32'(out_valid), 32'd0);
      chk("abort_quotient", 32'(quotient), 32'd0);
      chk("abort_remainder", 32'(remainder), 32'd0);
      chk("abort_div_zero", 32'(div_zero), 32'd0);
      reset = 1'b1;
      repeat (20) @(negedge clk);
    end
    run_div(16'd300, 8'd16, 16'd18, 8'd12, 1'b0, 1'b1, 17, "post_abort");
    repeat (25) @(negedge clk);
    chk("hold_quotient", 32'(quotient), 32'd18);
    chk("hold_remainder", 32'(remainder), 32'd12);

    for (int i = 0; i < 300; i++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(1, 255));
      p = 16'(a) * 16'(b);
      run_div(p, b, p / 16'(b), 8'(p % 16'(b)), 1'b0, 1'b1, 17, "sweep");
    end

    for (int n = 0; n < 60 && sb.size() != 0; n++) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
